// File: rtl/pipe_pkg.sv
// Shared pipeline constants: NOP encoding, default reset PC and instruction
// field offsets used by the decode stage.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory port and
// the IF/ID fields read by ID and the hazard unit.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic             Nop;
  logic             pcSel;
  logic [31:0]      branchTarget;
  logic [31:0]      imAddr;
  logic [31:0]      imData;
  logic [31:0]      IF_ID_pc4;
  logic [31:0]      IF_ID_instr;
  logic             IF_ID_valid;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  modport master (
    output Nop, pcSel, branchTarget, imData,
    input  imAddr, IF_ID_pc4, IF_ID_instr, IF_ID_valid, stallCnt, flushCnt
  );

  modport slave (
    input  Nop, pcSel, branchTarget, imData,
    output imAddr, IF_ID_pc4, IF_ID_instr, IF_ID_valid, stallCnt, flushCnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, instruction-memory address and IF/ID
// register, plus saturating stall/flush event counters.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter bit          FLUSH_ON_BRANCH = 1'b1,
  parameter int          CNT_W           = 16
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      id_pc4;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             redirect;
  logic             squash;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign pc_plus4 = pc + 32'd4;
  // A stall masks the redirect; ID holds it and presents it again.
  assign redirect = !bus.Nop && bus.pcSel;
  assign squash   = redirect && FLUSH_ON_BRANCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      id_pc4   <= 32'h0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!bus.Nop) begin
      pc     <= redirect ? word_align(bus.branchTarget) : pc_plus4;
      id_pc4 <= pc_plus4;
      if (squash) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end else begin
        id_instr <= bus.imData;
        id_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.Nop),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (squash),
    .cnt (flush_cnt)
  );

  assign bus.imAddr      = pc;
  assign bus.IF_ID_pc4   = id_pc4;
  assign bus.IF_ID_instr = id_instr;
  assign bus.IF_ID_valid = id_valid;
  assign bus.stallCnt    = stall_cnt;
  assign bus.flushCnt    = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: default instance (flush on branch) and a
// small-counter, wrapping-PC, delay-slot instance.
module tb_if_id_stage;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_cmp;
  int   n_bad;

  if_id_stage_if #(.CNT_W(16)) bus_a ();
  if_id_stage_if #(.CNT_W(2))  bus_b ();

  if_id_stage #(
    .RESET_PC        (32'h0000_3000),
    .FLUSH_ON_BRANCH (1'b1),
    .CNT_W           (16)
  ) dut (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  if_id_stage #(
    .RESET_PC        (32'hFFFF_FFFC),
    .FLUSH_ON_BRANCH (1'b0),
    .CNT_W           (2)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Instruction memory model: a recognisable word derived from the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus_a.imData = mem(bus_a.imAddr);
  assign bus_b.imData = mem(bus_b.imAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    bus_a.Nop = 1'b0;
    bus_a.pcSel = 1'b0;
    bus_a.branchTarget = 32'h0;
    step();
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h3000) begin n_bad++; $display("FAIL reset_imaddr got %h want %h", bus_a.imAddr, 32'h3000); end
    n_cmp++; if (bus_a.IF_ID_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus_a.IF_ID_valid); end
    n_cmp++; if (bus_a.IF_ID_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", bus_a.IF_ID_instr); end
    n_cmp++; if (bus_a.IF_ID_pc4 !== 32'h0) begin n_bad++; $display("FAIL reset_pc4 got %h want 0", bus_a.IF_ID_pc4); end
    n_cmp++; if (bus_a.stallCnt !== 16'd0 || bus_a.flushCnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnts got %0d/%0d want 0/0", bus_a.stallCnt, bus_a.flushCnt); end
    rst_a = 1'b0;
    step();
    n_cmp++; if (bus_a.IF_ID_pc4 !== 32'h3004) begin n_bad++; $display("FAIL first_pc4 got %h want %h", bus_a.IF_ID_pc4, 32'h3004); end
    n_cmp++; if (bus_a.IF_ID_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", bus_a.IF_ID_valid); end
    n_cmp++; if (bus_a.IF_ID_instr !== 32'hC0DE_3000) begin n_bad++; $display("FAIL first_instr got %h want %h", bus_a.IF_ID_instr, 32'hC0DE_3000); end
    n_cmp++; if (bus_a.imAddr !== 32'h3004) begin n_bad++; $display("FAIL first_imaddr got %h want %h", bus_a.imAddr, 32'h3004); end
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h3008) begin n_bad++; $display("FAIL second_imaddr got %h want %h", bus_a.imAddr, 32'h3008); end
  endtask

  task automatic test_stall();
    bus_a.Nop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus_a.imAddr !== 32'h3008) begin n_bad++; $display("FAIL stall_imaddr[%0d] got %h want %h", i, bus_a.imAddr, 32'h3008); end
      n_cmp++; if (bus_a.IF_ID_pc4 !== 32'h3008 || bus_a.IF_ID_instr !== 32'hC0DE_3004 || bus_a.IF_ID_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall_ifid[%0d] got %h/%h/%b want 3008/c0de3004/1", i, bus_a.IF_ID_pc4, bus_a.IF_ID_instr, bus_a.IF_ID_valid);
      end
    end
    n_cmp++; if (bus_a.stallCnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt got %0d want 3", bus_a.stallCnt); end
    bus_a.Nop = 1'b0;
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h300C || bus_a.IF_ID_instr !== 32'hC0DE_3008) begin
      n_bad++; $display("FAIL stall_resume got %h/%h want 300c/c0de3008", bus_a.imAddr, bus_a.IF_ID_instr);
    end
  endtask

  task automatic test_redirect();
    bus_a.pcSel = 1'b1;
    bus_a.branchTarget = 32'h0000_3041;
    step();
    bus_a.pcSel = 1'b0;
    n_cmp++; if (bus_a.imAddr !== 32'h3040) begin n_bad++; $display("FAIL redir_imaddr got %h want %h", bus_a.imAddr, 32'h3040); end
    n_cmp++; if (bus_a.IF_ID_valid !== 1'b0 || bus_a.IF_ID_instr !== 32'h0) begin n_bad++; $display("FAIL redir_squash got %b/%h want 0/0", bus_a.IF_ID_valid, bus_a.IF_ID_instr); end
    n_cmp++; if (bus_a.IF_ID_pc4 !== 32'h3010) begin n_bad++; $display("FAIL redir_pc4 got %h want %h", bus_a.IF_ID_pc4, 32'h3010); end
    n_cmp++; if (bus_a.flushCnt !== 16'd1) begin n_bad++; $display("FAIL redir_flushcnt got %0d want 1", bus_a.flushCnt); end
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h3044 || bus_a.IF_ID_instr !== 32'hC0DE_3040 || bus_a.IF_ID_valid !== 1'b1) begin
      n_bad++; $display("FAIL redir_after got %h/%h/%b want 3044/c0de3040/1", bus_a.imAddr, bus_a.IF_ID_instr, bus_a.IF_ID_valid);
    end
  endtask

  task automatic test_stall_vs_redirect();
    bus_a.Nop = 1'b1;
    bus_a.pcSel = 1'b1;
    bus_a.branchTarget = 32'h0000_3100;
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h3044) begin n_bad++; $display("FAIL both_imaddr got %h want %h", bus_a.imAddr, 32'h3044); end
    n_cmp++; if (bus_a.flushCnt !== 16'd1 || bus_a.stallCnt !== 16'd4) begin n_bad++; $display("FAIL both_cnts got %0d/%0d want 1/4", bus_a.flushCnt, bus_a.stallCnt); end
    n_cmp++; if (bus_a.IF_ID_valid !== 1'b1 || bus_a.IF_ID_pc4 !== 32'h3044) begin n_bad++; $display("FAIL both_ifid got %b/%h want 1/3044", bus_a.IF_ID_valid, bus_a.IF_ID_pc4); end
    bus_a.Nop = 1'b0;
    step();
    bus_a.pcSel = 1'b0;
    n_cmp++; if (bus_a.imAddr !== 32'h3100) begin n_bad++; $display("FAIL both_redir_imaddr got %h want %h", bus_a.imAddr, 32'h3100); end
    n_cmp++; if (bus_a.flushCnt !== 16'd2 || bus_a.IF_ID_valid !== 1'b0 || bus_a.IF_ID_pc4 !== 32'h3048) begin
      n_bad++; $display("FAIL both_redir got %0d/%b/%h want 2/0/3048", bus_a.flushCnt, bus_a.IF_ID_valid, bus_a.IF_ID_pc4);
    end
  endtask

  task automatic test_reset_drops_redirect();
    rst_a = 1'b1;
    bus_a.pcSel = 1'b1;
    bus_a.branchTarget = 32'h0000_5000;
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h3000) begin n_bad++; $display("FAIL rstredir_imaddr got %h want %h", bus_a.imAddr, 32'h3000); end
    n_cmp++; if (bus_a.stallCnt !== 16'd0 || bus_a.flushCnt !== 16'd0 || bus_a.IF_ID_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstredir_state got %0d/%0d/%b want 0/0/0", bus_a.stallCnt, bus_a.flushCnt, bus_a.IF_ID_valid);
    end
    rst_a = 1'b0;
    bus_a.pcSel = 1'b0;
    step();
    n_cmp++; if (bus_a.imAddr !== 32'h3004) begin n_bad++; $display("FAIL rstredir_resume got %h want %h", bus_a.imAddr, 32'h3004); end
  endtask

  task automatic test_wrap();
    step();
    n_cmp++; if (bus_b.imAddr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_reset got %h want fffffffc", bus_b.imAddr); end
    rst_b = 1'b0;
    step();
    n_cmp++; if (bus_b.imAddr !== 32'h0 || bus_b.IF_ID_pc4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h/%h want 0/0", bus_b.imAddr, bus_b.IF_ID_pc4); end
    n_cmp++; if (bus_b.IF_ID_instr !== 32'hC0DE_FFFC || bus_b.IF_ID_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_instr got %h/%b want c0defffc/1", bus_b.IF_ID_instr, bus_b.IF_ID_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    bus_b.Nop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++; if (bus_b.stallCnt !== want) begin n_bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, bus_b.stallCnt, want); end
    end
    n_cmp++; if (bus_b.imAddr !== 32'h0) begin n_bad++; $display("FAIL sat_hold got %h want 0", bus_b.imAddr); end
    bus_b.Nop = 1'b0;
  endtask

  task automatic test_delay_slot();
    bus_b.pcSel = 1'b1;
    bus_b.branchTarget = 32'h0000_0202;
    step();
    bus_b.pcSel = 1'b0;
    n_cmp++; if (bus_b.imAddr !== 32'h200) begin n_bad++; $display("FAIL ds_imaddr got %h want 200", bus_b.imAddr); end
    n_cmp++; if (bus_b.IF_ID_valid !== 1'b1 || bus_b.IF_ID_instr !== 32'hC0DE_0000 || bus_b.IF_ID_pc4 !== 32'h4) begin
      n_bad++; $display("FAIL ds_ifid got %b/%h/%h want 1/c0de0000/4", bus_b.IF_ID_valid, bus_b.IF_ID_instr, bus_b.IF_ID_pc4);
    end
    n_cmp++; if (bus_b.flushCnt !== 2'd0) begin n_bad++; $display("FAIL ds_flushcnt got %0d want 0", bus_b.flushCnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_b = 1'b1;
    bus_b.Nop = 1'b0;
    bus_b.pcSel = 1'b0;
    bus_b.branchTarget = 32'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_stall_vs_redirect();
    test_reset_drops_redirect();
    test_wrap();
    test_saturation();
    test_delay_slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
